bbox_display_ctrl: RTL and testbench
====================================

# bbox_display_ctrl

Frame-synchronous display scheduler for the bounding-box coordinates produced by the convolution/denoise stage. It captures top/bottom/left/right atomically once per frame at vertical sync, then time-multiplexes them as pages onto the six 7-segment digit nibbles. Pages advance automatically every few frames, or manually from a debounced push button. It sits between the filter pipeline's coordinate outputs and the Hex27Seg decoders at top level, and drives the "no object" LEDs.

## Interface
- DWELL_FRAMES, 60: frames each page is shown in auto mode (1..255).
- MANUAL_TIMEOUT, 600: frames without a key press before manual mode reverts to auto (1..1023).
- DEBOUNCE_CYCLES, 250000: clock cycles the synchronized key must be stable before it is accepted.
- clk  in  1  pixel clock, same as filter pipeline.
- rstn  in  1  asynchronous, active-low reset.
- vs_ni  in  1  active-low vertical sync from filter pipeline output.
- top_i, bot_i, left_i, right_i  in  13 each  coordinates; bit 12 = no-object flag, [11:0] = value.
- key_ni  in  1  raw active-low push button, asynchronous to clk.
- hex_num_o  out  24  six nibbles; [3:0] = digit 0 … [23:20] = digit 5.
- page_o  out  2  current page: 0 = TB, 1 = LR, 2 = WH.
- manual_o  out  1  high while in manual mode.
- flag_o  out  2  snapshotted no-object flags: [1] = top, [0] = bottom.

## Operation
- Frame tick: vs_ni is registered, and a tick fires on the first cycle vs_ni is low after being high. A single low cycle is still one tick.
- Snapshot: on a tick, all four 13-bit inputs are loaded into shadow registers in the same cycle. Between ticks, input changes are ignored.
- Page contents:
  - TB: digits 2..0 = top[11:0]; digits 5..3 = bot[11:0].
  - LR: digits 2..0 = left; digits 5..3 = right.
  - WH: digits 2..0 = width = right − left; digits 5..3 = height = bot − top. Both are 12-bit unsigned.
  - WH clamps a result to 0 if the subtraction would be negative, or if any flag in its pair is set.
- Mode FSM states AUTO and MANUAL; reset state is AUTO.
  - AUTO: a frame counter increments on each tick. On reaching DWELL_FRAMES it clears and the page advances.
  - Any accepted key press: page advances, state goes to MANUAL, and the timeout counter clears.
  - MANUAL: the timeout counter increments on each tick. On reaching MANUAL_TIMEOUT the state goes to AUTO and the dwell counter clears. The page is unchanged.
- Page order: TB → LR → WH → TB. Without the WH page, the order is TB → LR → TB.
- Key path:
  - 2-flop synchronizer, then the debounce counter.
  - An accepted press is a single-cycle pulse on the stable high→low transition. Releasing the key produces no event.
  - Holding the key produces exactly one press.
- Simultaneous events in the same cycle:
  - Key press and dwell expiry: the key wins. The page advances once and the dwell counter clears.
  - Key press and manual timeout: the key wins and the state stays MANUAL.
- Reset mid-operation:
  - All registers clear asynchronously. The next tick after reset release performs a normal snapshot.
  - A key held through reset release is not accepted until it has been released and pressed again.

## Timing
- Reset values: hex_num_o = 0, page_o = 0, manual_o = 0, flag_o = 0. Shadow registers, counters and the synchronizer all reset to 0; the key synchronizer resets to the released level (1).
- Tick: the cycle after vs_ni is first sampled low.
- Snapshot registers: update on the tick cycle.
- hex_num_o and flag_o: registered, valid 1 cycle after the snapshot or page change. WH subtraction fits within that cycle.
- Key latency: 2 sync cycles + DEBOUNCE_CYCLES + 1 cycle to the press pulse. page_o updates on the next cycle.
- Dwell counter: 8 bits. Timeout counter: 10 bits. Debounce counter width = $clog2(DEBOUNCE_CYCLES+1).

## Configuration
- BBOX_WH_PAGE_EN defined: the WH page and its subtractors/clamps are present, giving three pages.
- BBOX_WH_PAGE_EN undefined:
  - Only TB and LR exist, and page_o never equals 2.
  - The subtraction logic is not synthesized.
  - Key press and dwell expiry both toggle between pages 0 and 1.

## Structure
- Package bbox_disp_pkg holds:
  - page enum PAGE_TB/PAGE_LR/PAGE_WH;
  - mode enum MODE_AUTO/MODE_MANUAL;
  - COORD_W = 13 and FLAG_BIT = 12;
  - NUM_DIGITS = 6.
- Sub-module key_debounce (synchronizer + debounce counter + press-pulse generation), parameterized by DEBOUNCE_CYCLES.
- Page FSM, counters, snapshot and digit mux stay in bbox_display_ctrl.

## Test plan
- Snapshot: DWELL_FRAMES = 4, DEBOUNCE_CYCLES = 4.
  - Stimulus: top = 0x012, bot = 0x1A3, inputs changing mid-frame, then a vs_ni falling edge.
  - Required: hex_num_o = 0x1A3012 on page TB. Mid-frame input changes have no effect until the next edge.
- Auto rotation (macro defined):
  - Stimulus: 4 ticks, 8 ticks, then 12 ticks.
  - Required: page_o = 1 after 4 ticks, 2 after 8, back to 0 after 12.
  - Required on page LR with left = 0x040, right = 0x280: hex_num_o = 0x280040.
- WH arithmetic (macro defined):
  - left = 0x040, right = 0x280, top = 0x010, bot = 0x0F0: hex_num_o = 0x0E0240.
  - right = 0x030, left = 0x040: width = 0.
  - top[12] = 1: height = 0 and flag_o[1] = 1.
- Manual mode, MANUAL_TIMEOUT = 3:
  - Key low for 3 cycles: no page change.
  - Key low for ≥ 2 + DEBOUNCE_CYCLES cycles: page_o +1 and manual_o = 1.
  - 3 ticks with no press: manual_o = 0 and the page is held.
- Collision: key press pulse in the same cycle as dwell expiry → page advances exactly once and the dwell counter is 0.
- Macro off and reset:
  - Without BBOX_WH_PAGE_EN, page_o cycles 0, 1, 0 and never reaches 2.
  - rstn pulsed low mid-debounce with the key held: all outputs read 0 immediately, and no press is accepted until the key is released and pressed again.

Source files
------------

// File: rtl/bbox_disp_pkg.sv
// bbox_disp_pkg: shared types and constants for the bounding-box display
// scheduler (page/mode enums, coordinate layout, digit count).
package bbox_disp_pkg;

  typedef enum logic [1:0] {
    PAGE_TB = 2'd0,
    PAGE_LR = 2'd1,
    PAGE_WH = 2'd2
  } page_e;

  typedef enum logic {
    MODE_AUTO   = 1'b0,
    MODE_MANUAL = 1'b1
  } mode_e;

  localparam int COORD_W    = 13;
  localparam int FLAG_BIT   = 12;
  localparam int VAL_W      = FLAG_BIT;  // value field is [FLAG_BIT-1:0]
  localparam int NUM_DIGITS = 6;

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer + stability counter for an active-low
// push button. Emits a single-cycle press pulse on an accepted high->low
// transition; releases produce no event.
//   clk, rstn : clock, async active-low reset
//   key_ni    : raw active-low key, asynchronous to clk
//   press_o   : one-cycle pulse per accepted press
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rstn,
  input  logic key_ni,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  // The debounced level resets to "pressed" (0) while the synchronizer
  // resets to "released" (1). A key held through reset therefore matches
  // the debounced level and is ignored; a released key debounces to 1
  // silently. Only a fresh press after a seen release produces a pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      stable  <= 1'b0;
      cnt     <= '0;
      press_o <= 1'b0;
    end else begin
      sync1   <= key_ni;
      sync2   <= sync1;
      press_o <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt     <= '0;
        stable  <= sync2;
        press_o <= ~sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/bbox_display_ctrl.sv
// bbox_display_ctrl: frame-synchronous display scheduler for bounding-box
// coordinates. Snapshots top/bot/left/right on each vsync falling edge and
// pages them onto six hex digits (TB, LR and optionally WH). Pages rotate
// every DWELL_FRAMES frames in auto mode or step on a debounced key press;
// manual mode reverts to auto after MANUAL_TIMEOUT frames without a press.
// Optional feature macro: BBOX_WH_PAGE_EN (adds the width/height page).
//   clk, rstn                  : pixel clock, async active-low reset
//   vs_ni                      : active-low vertical sync
//   top_i/bot_i/left_i/right_i : {no-object flag, 12-bit value}
//   key_ni                     : raw active-low push button
//   hex_num_o                  : six nibbles, [3:0] = digit 0
//   page_o                     : 0 = TB, 1 = LR, 2 = WH
//   manual_o                   : high in manual mode
//   flag_o                     : snapshotted flags {top, bot}
module bbox_display_ctrl
  import bbox_disp_pkg::*;
#(
  parameter int DWELL_FRAMES    = 60,
  parameter int MANUAL_TIMEOUT  = 600,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    vs_ni,
  input  logic [COORD_W-1:0]      top_i,
  input  logic [COORD_W-1:0]      bot_i,
  input  logic [COORD_W-1:0]      left_i,
  input  logic [COORD_W-1:0]      right_i,
  input  logic                    key_ni,
  output logic [4*NUM_DIGITS-1:0] hex_num_o,
  output logic [1:0]              page_o,
  output logic                    manual_o,
  output logic [1:0]              flag_o
);

  localparam logic [7:0] DWELL_LIM = 8'(DWELL_FRAMES);
  localparam logic [9:0] TMO_LIM   = 10'(MANUAL_TIMEOUT);

  function automatic page_e next_page(input page_e p);
`ifdef BBOX_WH_PAGE_EN
    case (p)
      PAGE_TB: next_page = PAGE_LR;
      PAGE_LR: next_page = PAGE_WH;
      default: next_page = PAGE_TB;
    endcase
`else
    next_page = (p == PAGE_TB) ? PAGE_LR : PAGE_TB;
`endif
  endfunction

  // ---- frame tick: first registered-low sample after a high one ----
  logic vs_q, vs_d, tick;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vs_q <= 1'b0;
      vs_d <= 1'b0;
    end else begin
      vs_q <= vs_ni;
      vs_d <= vs_q;
    end
  end
  assign tick = vs_d & ~vs_q;

  // ---- atomic snapshot ----
  logic [COORD_W-1:0] top_s, bot_s, left_s, right_s;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      top_s   <= '0;
      bot_s   <= '0;
      left_s  <= '0;
      right_s <= '0;
    end else if (tick) begin
      top_s   <= top_i;
      bot_s   <= bot_i;
      left_s  <= left_i;
      right_s <= right_i;
    end
  end

  // ---- key path ----
  logic key_press;
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
    .clk     (clk),
    .rstn    (rstn),
    .key_ni  (key_ni),
    .press_o (key_press)
  );

  // ---- mode / page FSM ----
  mode_e      mode_q, mode_n;
  page_e      page_q, page_n;
  logic [7:0] dwell_q, dwell_n;
  logic [9:0] tmo_q, tmo_n;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q  <= MODE_AUTO;
      page_q  <= PAGE_TB;
      dwell_q <= '0;
      tmo_q   <= '0;
    end else begin
      mode_q  <= mode_n;
      page_q  <= page_n;
      dwell_q <= dwell_n;
      tmo_q   <= tmo_n;
    end
  end

  // A press takes priority over any same-cycle tick event, so the page
  // moves at most once per cycle and a press always lands in MANUAL.
  always_comb begin
    mode_n  = mode_q;
    page_n  = page_q;
    dwell_n = dwell_q;
    tmo_n   = tmo_q;
    if (key_press) begin
      page_n  = next_page(page_q);
      mode_n  = MODE_MANUAL;
      dwell_n = '0;
      tmo_n   = '0;
    end else if (tick) begin
      case (mode_q)
        MODE_AUTO: begin
          if (dwell_q + 8'd1 == DWELL_LIM) begin
            dwell_n = '0;
            page_n  = next_page(page_q);
          end else begin
            dwell_n = dwell_q + 8'd1;
          end
        end
        default: begin
          if (tmo_q + 10'd1 == TMO_LIM) begin
            mode_n  = MODE_AUTO;
            dwell_n = '0;
            tmo_n   = '0;
          end else begin
            tmo_n = tmo_q + 10'd1;
          end
        end
      endcase
    end
  end

  // ---- digit mux ----
`ifdef BBOX_WH_PAGE_EN
  logic [VAL_W-1:0] width, height;
  always_comb begin
    width  = right_s[VAL_W-1:0] - left_s[VAL_W-1:0];
    height = bot_s[VAL_W-1:0] - top_s[VAL_W-1:0];
    if (right_s[FLAG_BIT] | left_s[FLAG_BIT] |
        (right_s[VAL_W-1:0] < left_s[VAL_W-1:0]))
      width = '0;
    if (bot_s[FLAG_BIT] | top_s[FLAG_BIT] |
        (bot_s[VAL_W-1:0] < top_s[VAL_W-1:0]))
      height = '0;
  end
`else
  // left/right flags only feed the WH clamps
  logic unused_lr_flags;
  assign unused_lr_flags = left_s[FLAG_BIT] ^ right_s[FLAG_BIT];
`endif

  logic [4*NUM_DIGITS-1:0] hex_n;
  always_comb begin
    hex_n = {bot_s[VAL_W-1:0], top_s[VAL_W-1:0]};
    case (page_q)
      PAGE_LR: hex_n = {right_s[VAL_W-1:0], left_s[VAL_W-1:0]};
`ifdef BBOX_WH_PAGE_EN
      PAGE_WH: hex_n = {height, width};
`endif
      default: ;
    endcase
  end

  logic [4*NUM_DIGITS-1:0] hex_q;
  logic [1:0]              flag_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hex_q  <= '0;
      flag_q <= '0;
    end else begin
      hex_q  <= hex_n;
      flag_q <= {top_s[FLAG_BIT], bot_s[FLAG_BIT]};
    end
  end

  assign hex_num_o = hex_q;
  assign flag_o    = flag_q;
  assign page_o    = page_q;
  assign manual_o  = (mode_q == MODE_MANUAL);

endmodule

// File: tb/tb_bbox_display_ctrl.sv
// tb_bbox_display_ctrl: directed bench for bbox_display_ctrl with
// DWELL_FRAMES = 4, MANUAL_TIMEOUT = 3, DEBOUNCE_CYCLES = 4. Works with or
// without BBOX_WH_PAGE_EN; expectations follow the build.
module tb_bbox_display_ctrl;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        vs_ni = 1'b1;
  logic        key_ni = 1'b1;
  logic [12:0] top_i = '0, bot_i = '0, left_i = '0, right_i = '0;
  logic [23:0] hex_num_o;
  logic [1:0]  page_o, flag_o;
  logic        manual_o;

  int total = 0;
  int bad   = 0;
  int np;
  int exp_page;

  always #5 clk = ~clk;

  bbox_display_ctrl #(
    .DWELL_FRAMES    (4),
    .MANUAL_TIMEOUT  (3),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .vs_ni     (vs_ni),
    .top_i     (top_i),
    .bot_i     (bot_i),
    .left_i    (left_i),
    .right_i   (right_i),
    .key_ni    (key_ni),
    .hex_num_o (hex_num_o),
    .page_o    (page_o),
    .manual_o  (manual_o),
    .flag_o    (flag_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // one vsync pulse; returns with the snapshot and outputs settled
  task automatic frame();
    vs_ni = 1'b0;
    cyc(2);
    vs_ni = 1'b1;
    cyc(3);
  endtask

  initial begin
`ifdef BBOX_WH_PAGE_EN
    np = 3;
`else
    np = 2;
`endif
    // reset state
    cyc(3);
    chk("rst_hex", hex_num_o, 0);
    chk("rst_page", page_o, 0);
    chk("rst_manual", manual_o, 0);
    chk("rst_flag", flag_o, 0);
    rstn = 1'b1;
    cyc(10);
    chk("idle_page", page_o, 0);

    // snapshot
    top_i = 13'h012; bot_i = 13'h1A3; left_i = 13'h040; right_i = 13'h280;
    frame();
    chk("snap_hex", hex_num_o, 24'h1A3012);
    chk("snap_page", page_o, 0);
    top_i = 13'h777; bot_i = 13'h555;
    cyc(5);
    chk("midframe_hold", hex_num_o, 24'h1A3012);

    // auto rotation, ticks 2..12
    top_i = 13'h010; bot_i = 13'h0F0;
    for (int n = 2; n <= 12; n++) begin
      frame();
      chk("auto_page", page_o, (n / 4) % np);
      if (n == 4) chk("lr_hex", hex_num_o, 24'h280040);
      if (n == 8) chk("tick8_hex", hex_num_o, (np == 3) ? 24'h0E0240 : 24'h0F0010);
    end

    // WH clamps, ticks 13..22
    for (int n = 13; n <= 22; n++) begin
      if (n == 13) right_i = 13'h030;
      if (n == 21) begin top_i = 13'h1010; right_i = 13'h280; end
      frame();
      chk("auto_page2", page_o, (n / 4) % np);
      if (n == 20) chk("wclamp_hex", hex_num_o, (np == 3) ? 24'h0E0000 : 24'h030040);
      if (n == 21) begin
        chk("hclamp_hex", hex_num_o, (np == 3) ? 24'h000240 : 24'h280040);
        chk("flag_top", flag_o, 2'b10);
      end
    end
    top_i = 13'h010;
    exp_page = (22 / 4) % np;

    // short glitch is rejected
    key_ni = 1'b0; cyc(3); key_ni = 1'b1; cyc(10);
    chk("glitch_page", page_o, exp_page);
    chk("glitch_manual", manual_o, 0);

    // accepted press, held: exactly one step
    key_ni = 1'b0; cyc(D + 6);
    exp_page = (exp_page + 1) % np;
    chk("press_page", page_o, exp_page);
    chk("press_manual", manual_o, 1);
    cyc(20);
    chk("hold_once", page_o, exp_page);
    key_ni = 1'b1; cyc(10);
    chk("release_page", page_o, exp_page);

    // manual timeout after 3 ticks, page held; dwell restarts from 0
    frame(); frame();
    chk("tmo2_manual", manual_o, 1);
    frame();
    chk("tmo3_manual", manual_o, 0);
    chk("tmo3_page", page_o, exp_page);
    frame(); frame(); frame();
    chk("auto3_page", page_o, exp_page);
    frame();
    exp_page = (exp_page + 1) % np;
    chk("auto4_page", page_o, exp_page);

    // collision: press pulse in the same cycle as the 4th tick
    frame(); frame(); frame();
    chk("pre_coll_page", page_o, exp_page);
    key_ni = 1'b0; cyc(5);
    vs_ni = 1'b0; cyc(2);
    vs_ni = 1'b1; cyc(4);
    exp_page = (exp_page + 1) % np;
    chk("coll_page", page_o, exp_page);
    chk("coll_manual", manual_o, 1);
    chk("coll_dwell", dut.dwell_q, 0);
    key_ni = 1'b1; cyc(10);
    frame(); frame(); frame();
    chk("coll_tmo_manual", manual_o, 0);

    // reset mid-debounce with key held
    key_ni = 1'b0; cyc(4);
    rstn = 1'b0; #1;
    chk("rst2_hex", hex_num_o, 0);
    chk("rst2_page", page_o, 0);
    chk("rst2_manual", manual_o, 0);
    chk("rst2_flag", flag_o, 0);
    cyc(2);
    rstn = 1'b1; cyc(20);
    chk("held_page", page_o, 0);
    chk("held_manual", manual_o, 0);
    key_ni = 1'b1; cyc(10);
    key_ni = 1'b0; cyc(10);
    chk("repress_page", page_o, 1);
    chk("repress_manual", manual_o, 1);
    key_ni = 1'b1; cyc(10);
    frame();
    chk("post_rst_snap", hex_num_o, 24'h280040);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
